// File: rtl/ginv32.sv
// GF(2^32) multiplicative inverter using the binary extended Euclidean algorithm.
// Performs one reduction step per cycle and uses a req/rdy level handshake.
module ginv32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_a,
  input  logic [31:0] i_m,
  output logic [31:0] o_p,
  output logic        o_rdy,
  output logic        o_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state, w_state;
  logic [32:0] r_u, r_v, r_f, w_u, w_v, w_f;
  logic [31:0] r_g1, r_g2, w_g1, w_g2;
  logic [6:0]  r_step, w_step;
  logic [31:0] r_p, w_p;
  logic        r_err, w_err;
  logic        r_rdy;
  logic [32:0] w_uxv;
  logic [5:0]  w_du, w_dv;

  function automatic logic [5:0] deg33(input logic [32:0] x);
    logic [5:0] d;
    d = '0;
    for (int i = 0; i < 33; i++)
      if (x[i]) d = 6'(i);
    return d;
  endfunction

  // Divide g by x modulo f: add f first when g is odd so the shift is exact.
  function automatic logic [31:0] halve(input logic [31:0] g, input logic [32:0] f);
    logic [32:0] t;
    t = g[0] ? ({1'b0, g} ^ f) : {1'b0, g};
    return t[32:1];
  endfunction

  assign w_uxv = r_u ^ r_v;
  assign w_du  = deg33(r_u);
  assign w_dv  = deg33(r_v);

  always_comb begin
    w_state = r_state;
    w_u     = r_u;
    w_v     = r_v;
    w_f     = r_f;
    w_g1    = r_g1;
    w_g2    = r_g2;
    w_step  = r_step;
    w_p     = r_p;
    w_err   = r_err;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_u     = {1'b0, i_a};
          w_v     = {1'b1, i_m};
          w_f     = {1'b1, i_m};
          w_g1    = 32'd1;
          w_g2    = 32'd0;
          w_step  = 7'd0;
          w_state = S_RUN;
        end
      end
      S_RUN: begin
        // Abort takes priority over any completion in the same cycle.
        if (!i_req) begin
          w_state = S_IDLE;
        end else if (r_u == 33'd1) begin
          w_p     = r_g1;
          w_err   = 1'b0;
          w_state = S_DONE;
        end else if (r_v == 33'd1) begin
          w_p     = r_g2;
          w_err   = 1'b0;
          w_state = S_DONE;
        end else if (r_u == 33'd0 || r_v == 33'd0 || r_step == 7'd64) begin
          w_p     = 32'd0;
          w_err   = 1'b1;
          w_state = S_DONE;
        end else begin
          w_step = r_step + 7'd1;
          if (!r_u[0]) begin
            w_u  = r_u >> 1;
            w_g1 = halve(r_g1, r_f);
          end else if (!r_v[0]) begin
            w_v  = r_v >> 1;
            w_g2 = halve(r_g2, r_f);
          end else if (w_du > w_dv) begin
            w_u  = w_uxv >> 1;
            w_g1 = halve(r_g1 ^ r_g2, r_f);
          end else begin
            w_v  = w_uxv >> 1;
            w_g2 = halve(r_g1 ^ r_g2, r_f);
          end
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_u     <= '0;
      r_v     <= '0;
      r_f     <= '0;
      r_g1    <= '0;
      r_g2    <= '0;
      r_step  <= '0;
      r_p     <= '0;
      r_err   <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_u     <= w_u;
      r_v     <= w_v;
      r_f     <= w_f;
      r_g1    <= w_g1;
      r_g2    <= w_g2;
      r_step  <= w_step;
      r_p     <= w_p;
      r_err   <= w_err;
      r_rdy   <= (r_state == S_DONE);
    end
  end

  assign o_p   = r_p;
  assign o_err = r_err;
  assign o_rdy = r_rdy;

endmodule
